// File: rtl/addsub_pkg.sv
// Shared add/subtract encoding used by the word-level ALU to drive the per-bit sub select.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit1_add_if.sv
// Signal bundle for one bit1_add cell; sub is present only when BIT1_ADD_SUB_EN is defined.
interface bit1_add_if;

    logic a;
    logic b;
    logic cin;
`ifdef BIT1_ADD_SUB_EN
    logic sub;
`endif
    logic sum;
    logic carry;
    logic p;
    logic g;
    logic sum_q;
    logic carry_q;

`ifdef BIT1_ADD_SUB_EN
    modport master (output a, b, cin, sub, input sum, carry, p, g, sum_q, carry_q);
    modport slave  (input a, b, cin, sub, output sum, carry, p, g, sum_q, carry_q);
`else
    modport master (output a, b, cin, input sum, carry, p, g, sum_q, carry_q);
    modport slave  (input a, b, cin, output sum, carry, p, g, sum_q, carry_q);
`endif

endinterface

// File: rtl/half_adder.sv
// Half adder: s = x ^ y, c = x & y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/bit1_add.sv
// One-bit full adder cell with propagate/generate and registered sum/carry.
// Optional subtract select compiled in with BIT1_ADD_SUB_EN.
module bit1_add
    import addsub_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    bit1_add_if.slave bus
);

    logic w_be;
    logic w_p;
    logic w_g;
    logic w_sum;
    logic w_pc;
    logic w_carry;
    logic r_sum_q;
    logic r_carry_q;

    // Word-level subtract also needs cin=1 on bit 0; that is the chain's job, not the cell's.
`ifdef BIT1_ADD_SUB_EN
    assign w_be = bus.b ^ (bus.sub == OP_SUB);
`else
    assign w_be = bus.b;
`endif

    half_adder u_ha_pg (
        .x (bus.a),
        .y (w_be),
        .s (w_p),
        .c (w_g)
    );

    half_adder u_ha_sum (
        .x (w_p),
        .y (bus.cin),
        .s (w_sum),
        .c (w_pc)
    );

    assign w_carry = w_g | w_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q   <= 1'b0;
            r_carry_q <= 1'b0;
        end else begin
            r_sum_q   <= w_sum;
            r_carry_q <= w_carry;
        end
    end

    assign bus.p       = w_p;
    assign bus.g       = w_g;
    assign bus.sum     = w_sum;
    assign bus.carry   = w_carry;
    assign bus.sum_q   = r_sum_q;
    assign bus.carry_q = r_carry_q;

endmodule

// File: tb/tb_bit1_add.sv
// Directed-vector bench for bit1_add: truth table, p/g, registered path, reset and a 4-bit chain.
module tb_bit1_add;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sub;
        logic sum;
        logic carry;
        logic p;
        logic g;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    bit1_add_if dif ();

    bit1_add u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    // 4-bit ripple chain of cells
    logic [3:0] ch_a;
    logic [3:0] ch_b;
    logic       ch_sub;
    logic [4:0] ch_c;
    logic [3:0] ch_sum;

    for (genvar i = 0; i < 4; i++) begin : g_chain
        bit1_add_if cif ();
        assign cif.a   = ch_a[i];
        assign cif.b   = ch_b[i];
        assign cif.cin = ch_c[i];
`ifdef BIT1_ADD_SUB_EN
        assign cif.sub = ch_sub;
`endif
        assign ch_c[i+1]  = cif.carry;
        assign ch_sum[i]  = cif.sum;
        bit1_add u_cell (
            .clk (clk),
            .rst (rst),
            .bus (cif)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic a, input logic b, input logic cin, input logic sub,
                           input logic sum, input logic carry, input logic p, input logic g);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.carry = carry; v.p = p; v.g = g;
        vecs.push_back(v);
    endtask

    task automatic chain(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic cin0, input logic sub,
                         input logic [3:0] exp_sum, input logic exp_co);
        ch_a = a;
        ch_b = b;
        ch_c[0] = cin0;
        ch_sub = sub;
        #3;
        check({name, "_sum"}, {4'b0, ch_sum}, {4'b0, exp_sum});
        check({name, "_co"}, {7'b0, ch_c[4]}, {7'b0, exp_co});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ch_a = '0; ch_b = '0; ch_c[0] = 1'b0; ch_sub = 1'b0;

        //      a  b  cin sub  sum carry p  g
        add_vec(0, 0, 0, 0,   0, 0,    0, 0);
        add_vec(0, 0, 1, 0,   1, 0,    0, 0);
        add_vec(0, 1, 0, 0,   1, 0,    1, 0);
        add_vec(0, 1, 1, 0,   0, 1,    1, 0);
        add_vec(1, 0, 0, 0,   1, 0,    1, 0);
        add_vec(1, 0, 1, 0,   0, 1,    1, 0);
        add_vec(1, 1, 0, 0,   0, 1,    0, 1);
        add_vec(1, 1, 1, 0,   1, 1,    0, 1);
`ifdef BIT1_ADD_SUB_EN
        add_vec(1, 0, 1, 1,   1, 1,    0, 1);
        add_vec(0, 1, 1, 1,   1, 0,    0, 0);
        add_vec(1, 1, 1, 1,   0, 1,    1, 0);
        add_vec(0, 0, 0, 1,   1, 0,    1, 0);
`endif

        rst = 1'b1;
        dif.a = 1'b1; dif.b = 1'b1; dif.cin = 1'b1;
`ifdef BIT1_ADD_SUB_EN
        dif.sub = 1'b0;
`endif

        // Reset held across an edge with inputs 111
        @(posedge clk); #1;
        check("rst_sum_q", {7'b0, dif.sum_q}, 8'd0);
        check("rst_carry_q", {7'b0, dif.carry_q}, 8'd0);
        check("rst_comb_sum", {7'b0, dif.sum}, 8'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_sum_q", {7'b0, dif.sum_q}, 8'd1);
        check("rel_carry_q", {7'b0, dif.carry_q}, 8'd1);

        // Mid-cycle input change: comb follows, registers hold
        @(negedge clk);
        dif.a = 1'b0; dif.b = 1'b0; dif.cin = 1'b0;
        #1;
        check("mid_sum", {7'b0, dif.sum}, 8'd0);
        check("mid_carry", {7'b0, dif.carry}, 8'd0);
        check("mid_sum_q_hold", {7'b0, dif.sum_q}, 8'd1);
        check("mid_carry_q_hold", {7'b0, dif.carry_q}, 8'd1);
        @(posedge clk); #1;
        check("next_sum_q", {7'b0, dif.sum_q}, 8'd0);
        check("next_carry_q", {7'b0, dif.carry_q}, 8'd0);

        // Single-bit sum path into the register: 001 -> sum 1, carry 0
        @(negedge clk);
        dif.cin = 1'b1;
        @(posedge clk); #1;
        check("s1c0_sum_q", {7'b0, dif.sum_q}, 8'd1);
        check("s1c0_carry_q", {7'b0, dif.carry_q}, 8'd0);

        // Reset pulse between edges has no effect
        @(negedge clk);
        dif.a = 1'b1; dif.b = 1'b1; dif.cin = 1'b1;
        @(posedge clk); #1;
        check("load_sum_q", {7'b0, dif.sum_q}, 8'd1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("pulse_sum_q", {7'b0, dif.sum_q}, 8'd1);
        check("pulse_carry_q", {7'b0, dif.carry_q}, 8'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_pulse_sum_q", {7'b0, dif.sum_q}, 8'd1);
        check("post_pulse_carry_q", {7'b0, dif.carry_q}, 8'd1);

        // Table-driven combinational vectors
        for (int i = 0; i < vecs.size(); i++) begin
            dif.a = vecs[i].a;
            dif.b = vecs[i].b;
            dif.cin = vecs[i].cin;
`ifdef BIT1_ADD_SUB_EN
            dif.sub = vecs[i].sub;
`endif
            #5;
            check($sformatf("vec%0d_sum", i), {7'b0, dif.sum}, {7'b0, vecs[i].sum});
            check($sformatf("vec%0d_carry", i), {7'b0, dif.carry}, {7'b0, vecs[i].carry});
            check($sformatf("vec%0d_p", i), {7'b0, dif.p}, {7'b0, vecs[i].p});
            check($sformatf("vec%0d_g", i), {7'b0, dif.g}, {7'b0, vecs[i].g});
        end

        // Chain of four cells
        chain("add_5p3", 4'd5, 4'd3, 1'b0, 1'b0, 4'b1000, 1'b0);
        chain("add_9p7", 4'd9, 4'd7, 1'b0, 1'b0, 4'b0000, 1'b1);
        chain("add_15p0c", 4'd15, 4'd0, 1'b1, 1'b0, 4'b0000, 1'b1);
`ifdef BIT1_ADD_SUB_EN
        chain("sub_5m3", 4'd5, 4'd3, 1'b1, 1'b1, 4'b0010, 1'b1);
        chain("sub_3m5", 4'd3, 4'd5, 1'b1, 1'b1, 4'b1110, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
